// File: rtl/mux_serializer_p2s.sv
// mux_serializer_p2s
// Buffers bytes from the upstream 4:1 byte mux in a small FIFO and serializes
// them MSB-first onto a 1-bit lane, one bit per clock. When the FIFO is empty
// at a symbol boundary the COM filler symbol is sent instead, so the lane
// never stalls once it has started.
//
// Ports:
//   clk        - single clock, equal to the serial bit rate
//   reset      - asynchronous, active-low reset
//   in_data    - byte from the upstream mux
//   in_valid   - in_data is valid
//   in_ready   - FIFO can accept a byte (combinational, 0 while in reset)
//   data_out   - registered serial bit
//   valid_out  - serial lane active
//   sym_start  - data_out carries the MSB of a symbol
//   is_data    - current symbol is a FIFO byte (1) or COM (0)
//   fifo_count - current FIFO occupancy
module mux_serializer_p2s #(
    parameter int                 DATA_W     = 8,
    parameter int                 FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0]  COM_SYM    = 8'hBC
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          data_out,
    output logic                          valid_out,
    output logic                          sym_start,
    output logic                          is_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BC_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [BC_W-1:0]  LAST = BC_W'(DATA_W - 1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [BC_W-1:0]   bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] sym;
    logic              push;
    logic              pop;
    logic              load;

    assign in_ready   = reset & (count != FULL);
    assign push       = in_valid & in_ready;
    assign load       = (bit_cnt == LAST);
    // Pop only uses occupancy before this edge, so a byte pushed on the
    // load edge into an empty FIFO waits for the next slot.
    assign pop        = load & (count != '0);
    assign sym        = pop ? mem[rd_ptr] : COM_SYM;
    assign fifo_count = count;

    // Storage needs no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // bit_cnt resets to the last position so the first edge after release
    // is a load edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= LAST;
            shreg     <= '0;
            data_out  <= 1'b0;
            valid_out <= 1'b0;
            sym_start <= 1'b0;
            is_data   <= 1'b0;
        end else if (load) begin
            data_out  <= sym[DATA_W-1];
            shreg     <= sym << 1;
            bit_cnt   <= '0;
            sym_start <= 1'b1;
            valid_out <= 1'b1;
            is_data   <= pop;
        end else begin
            data_out  <= shreg[DATA_W-1];
            shreg     <= shreg << 1;
            bit_cnt   <= bit_cnt + BC_W'(1);
            sym_start <= 1'b0;
        end
    end

endmodule
